// File: rtl/write_back_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : write_back_arb_if
// Description : Execute-unit result handshake and register-write bus seen by
//               write_back_arb. The execute side drives the master modport,
//               the arbiter uses the slave modport.
// Revision    : 1.0 - initial release
// ============================================================================
interface write_back_arb_if #(
    parameter int N_SRC         = 2,
    parameter int LEN_PREG_ADDR = 6,
    parameter int LEN_WORD      = 32,
    parameter int LEN_CONTEXT   = 4
);
    logic [N_SRC-1:0]                  src_valid;
    logic [N_SRC-1:0]                  src_ready;
    logic [N_SRC*LEN_PREG_ADDR-1:0]    src_pa_rd;
    logic [N_SRC*LEN_WORD-1:0]         src_data;
    logic [N_SRC*LEN_CONTEXT-1:0]      src_context;
    logic                              branch_hazard;
    logic [LEN_CONTEXT-1:0]            hazard_context_info;
    logic [LEN_PREG_ADDR+LEN_WORD:0]   w_write_d_r;

    modport master (
        output src_valid, src_pa_rd, src_data, src_context,
        output branch_hazard, hazard_context_info,
        input  src_ready, w_write_d_r
    );

    modport slave (
        input  src_valid, src_pa_rd, src_data, src_context,
        input  branch_hazard, hazard_context_info,
        output src_ready, w_write_d_r
    );
endinterface
`default_nettype wire

// File: rtl/write_back_arb.sv
`default_nettype none
// ============================================================================
// Module      : write_back_arb
// Description : Buffers results from N_SRC execute units in per-source FIFOs
//               and serialises them, round-robin, into one register write
//               per cycle. Results of squashed branch contexts are dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module write_back_arb #(
    parameter int N_SRC         = 2,
    parameter int DEPTH         = 4,
    parameter int LEN_PREG_ADDR = 6,
    parameter int LEN_WORD      = 32,
    parameter int LEN_CONTEXT   = 4
) (
    input  logic             clk,
    input  logic             rstn,
    write_back_arb_if.slave  bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int PTR_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [N_SRC-1:0]               ready;
    logic [N_SRC-1:0]               push;
    logic [N_SRC-1:0]               pop;
    logic [N_SRC-1:0]               head_valid;
    logic [N_SRC-1:0]               head_live;
    logic [N_SRC-1:0]               head_squash;
    logic [N_SRC-1:0]               cand;
    logic [N_SRC-1:0]               grant;
    logic [N_SRC*LEN_PREG_ADDR-1:0] head_pa;
    logic [N_SRC*LEN_WORD-1:0]      head_data;
    logic [N_SRC*LEN_CONTEXT-1:0]   head_ctx;

    logic [PTR_W-1:0]               rr_ptr;
    logic [PTR_W-1:0]               grant_idx;
    logic                           grant_any;

    logic                           out_valid;
    logic [LEN_PREG_ADDR-1:0]       out_pa;
    logic [LEN_WORD-1:0]            out_data;
    logic [LEN_CONTEXT-1:0]         out_ctx;
    logic                           w_order;

    assign bus.src_ready = ready;

    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        logic [DEPTH-1:0]         live_mem;
        logic [LEN_PREG_ADDR-1:0] pa_mem   [DEPTH];
        logic [LEN_WORD-1:0]      data_mem [DEPTH];
        logic [LEN_CONTEXT-1:0]   ctx_mem  [DEPTH];
        logic [ADDR_W-1:0]        wr_ptr;
        logic [ADDR_W-1:0]        rd_ptr;
        logic [CNT_W-1:0]         count;
        logic [LEN_CONTEXT-1:0]   in_ctx;

        assign in_ctx = bus.src_context[i*LEN_CONTEXT +: LEN_CONTEXT];

        // Ready looks only at the registered count, so a full FIFO never
        // accepts even when it is popping in the same cycle.
        assign ready[i]      = ~rstn & (count != CNT_W'(DEPTH));
        assign push[i]       = bus.src_valid[i] & ready[i];
        assign head_valid[i] = (count != '0);
        assign head_live[i]  = head_valid[i] & live_mem[rd_ptr];
        assign head_squash[i] = bus.branch_hazard &
                                (|(ctx_mem[rd_ptr] & bus.hazard_context_info));
        // Dead heads drain every cycle without consuming a grant.
        assign pop[i]        = head_valid[i] & (~live_mem[rd_ptr] | grant[i]);

        assign head_pa  [i*LEN_PREG_ADDR +: LEN_PREG_ADDR] = pa_mem[rd_ptr];
        assign head_data[i*LEN_WORD      +: LEN_WORD]      = data_mem[rd_ptr];
        assign head_ctx [i*LEN_CONTEXT   +: LEN_CONTEXT]   = ctx_mem[rd_ptr];

        // Payload storage; contents are don't-care while their slot is empty.
        always_ff @(posedge clk) begin
            if (push[i]) begin
                pa_mem[wr_ptr]   <= bus.src_pa_rd[i*LEN_PREG_ADDR +: LEN_PREG_ADDR];
                data_mem[wr_ptr] <= bus.src_data[i*LEN_WORD +: LEN_WORD];
                ctx_mem[wr_ptr]  <= in_ctx;
            end
        end

        // Pointers, occupancy and live flags, including squash of stored
        // entries and of an entry being pushed under a matching hazard.
        always_ff @(posedge clk) begin
            if (rstn) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                live_mem <= '0;
            end else begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (bus.branch_hazard &&
                        (|(ctx_mem[j] & bus.hazard_context_info))) begin
                        live_mem[j] <= 1'b0;
                    end
                end
                if (push[i]) begin
                    live_mem[wr_ptr] <= ~(bus.branch_hazard &
                                          (|(in_ctx & bus.hazard_context_info)));
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop[i]) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count <= count + CNT_W'(push[i]) - CNT_W'(pop[i]);
            end
        end
    end

    // A head that dies through this cycle's squash is not a candidate.
    assign cand = head_live & ~head_squash;

    // Round-robin pick: first candidate at or after rr_ptr, wrapping.
    always_comb begin
        int               idx;
        logic [PTR_W-1:0] idx_s;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        idx_s     = '0;
        for (int off = 0; off < N_SRC; off++) begin
            idx = int'(rr_ptr) + off;
            if (idx >= N_SRC) begin
                idx = idx - N_SRC;
            end
            idx_s = PTR_W'(idx);
            if (!grant_any && cand[idx_s]) begin
                grant_any    = 1'b1;
                grant[idx_s] = 1'b1;
                grant_idx    = idx_s;
            end
        end
    end

    // Output register reloads every cycle; the pointer moves only on a grant.
    always_ff @(posedge clk) begin
        if (rstn) begin
            out_valid <= 1'b0;
            out_pa    <= '0;
            out_data  <= '0;
            out_ctx   <= '0;
            rr_ptr    <= '0;
        end else begin
            out_valid <= grant_any;
            out_pa    <= head_pa  [grant_idx*LEN_PREG_ADDR +: LEN_PREG_ADDR];
            out_data  <= head_data[grant_idx*LEN_WORD      +: LEN_WORD];
            out_ctx   <= head_ctx [grant_idx*LEN_CONTEXT   +: LEN_CONTEXT];
            if (grant_any) begin
                if (grant_idx == PTR_W'(N_SRC - 1)) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= grant_idx + 1'b1;
                end
            end
        end
    end

    // x0 is never written, and a squash kills the registered result at once.
    assign w_order = out_valid & (out_pa != '0) &
                     ~(bus.branch_hazard & (|(out_ctx & bus.hazard_context_info)));

    assign bus.w_write_d_r = {w_order, out_pa, out_data};

endmodule
`default_nettype wire

// File: tb/tb_write_back_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_write_back_arb
// Description : Directed, scoreboard-checked bench for write_back_arb.
//               Source is identified from data[31:28] (1 = source 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_write_back_arb;
    localparam int N_SRC = 2;
    localparam int DEPTH = 4;
    localparam int PA    = 6;
    localparam int W     = 32;
    localparam int C     = 4;
    localparam int NF    = 10;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    write_back_arb_if #(.N_SRC(N_SRC), .LEN_PREG_ADDR(PA), .LEN_WORD(W),
                        .LEN_CONTEXT(C)) bus ();

    write_back_arb #(.N_SRC(N_SRC), .DEPTH(DEPTH), .LEN_PREG_ADDR(PA),
                     .LEN_WORD(W), .LEN_CONTEXT(C))
        dut (.clk(clk), .rstn(rstn), .bus(bus));

    wire          w_order = bus.w_write_d_r[PA+W];
    wire [PA-1:0] w_pa    = bus.w_write_d_r[PA+W-1:W];
    wire [W-1:0]  w_d     = bus.w_write_d_r[W-1:0];

    int checks = 0;
    int errors = 0;
    logic [PA+W-1:0] q0[$];
    logic [PA+W-1:0] q1[$];
    int src_log[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input int s, input logic [PA-1:0] pa, input logic [W-1:0] d,
                         input logic [C-1:0] ctx, input bit exp_wr, output bit acc);
        bus.src_valid[s]               = 1'b1;
        bus.src_pa_rd[s*PA +: PA]      = pa;
        bus.src_data[s*W +: W]         = d;
        bus.src_context[s*C +: C]      = ctx;
        acc = bus.src_ready[s];
        if (acc && exp_wr) begin
            if (s == 0) q0.push_back({pa, d});
            else        q1.push_back({pa, d});
        end
    endtask

    task automatic idle(input int s);
        bus.src_valid[s] = 1'b0;
    endtask

    // Scoreboard: every emitted write must match the head of its source queue.
    always @(negedge clk) begin
        logic [PA+W-1:0] exp;
        bit              have;
        int              s;
        if (w_order === 1'b1) begin
            s    = (w_d[31:28] == 4'h1) ? 1 : 0;
            have = 1'b0;
            exp  = '0;
            if (s == 0 && q0.size() > 0) begin have = 1'b1; exp = q0.pop_front(); end
            if (s == 1 && q1.size() > 0) begin have = 1'b1; exp = q1.pop_front(); end
            checks++;
            assert ({1'b1, w_pa, w_d} === {have, exp}) else begin
                errors++;
                $error("FAIL write_src%0d observed %h expected %h (queued=%0d)",
                       s, {w_pa, w_d}, exp, have);
            end
            src_log.push_back(s);
        end
    end

    initial begin
        bit acc;
        int rem [2];
        int k   [2];
        bit full[2];

        rstn                    = 1'b1;
        bus.src_valid           = '1;
        bus.src_pa_rd           = '0;
        bus.src_data            = '0;
        bus.src_context         = '0;
        bus.branch_hazard       = 1'b0;
        bus.hazard_context_info = '0;

        // ---- reset defaults ----
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            chk("rst_ready", bus.src_ready, 2'b00);
            chk("rst_wbus", bus.w_write_d_r, '0);
        end
        step();
        rstn = 1'b0;
        bus.src_valid = '0;
        @(negedge clk);
        chk("rel_ready", bus.src_ready, 2'b11);

        // ---- single write latency ----
        step();
        drive(0, 6'd5, 32'hDEADBEEF, 4'b0001, 1'b1, acc);
        step();
        idle(0);
        @(negedge clk);
        chk("lat_c0_order", w_order, 1'b0);
        step();
        @(negedge clk);
        chk("lat_c1_order", w_order, 1'b1);
        chk("lat_c1_pa", w_pa, 6'd5);
        chk("lat_c1_data", w_d, 32'hDEADBEEF);
        step();
        @(negedge clk);
        chk("lat_c2_order", w_order, 1'b0);

        // ---- x0 suppression ----
        step();
        drive(0, 6'd0, 32'h0000_0111, 4'b0001, 1'b0, acc);
        step();
        drive(0, 6'd7, 32'h0000_0777, 4'b0001, 1'b1, acc);
        @(negedge clk);
        chk("x0_c0_order", w_order, 1'b0);
        step();
        idle(0);
        @(negedge clk);
        chk("x0_c1_order", w_order, 1'b0);
        step();
        @(negedge clk);
        chk("x0_c2_order", w_order, 1'b1);
        chk("x0_c2_pa", w_pa, 6'd7);
        step();

        // ---- round-robin fairness (last grant was source 0, so source 1 leads) ----
        src_log.delete();
        rem[0] = NF; rem[1] = NF; k[0] = 0; k[1] = 0; full[0] = 0; full[1] = 0;
        for (int cyc = 0; cyc < 60 && (rem[0] > 0 || rem[1] > 0); cyc++) begin
            step();
            for (int s = 0; s < 2; s++) begin
                if (!bus.src_ready[s]) full[s] = 1'b1;
                if (rem[s] > 0) begin
                    drive(s, 6'(s*16 + k[s] + 1), {4'(s), 20'h0, 8'(k[s])},
                          4'b0010, 1'b1, acc);
                    if (acc) begin rem[s]--; k[s]++; end
                end else begin
                    idle(s);
                end
            end
        end
        step();
        idle(0); idle(1);
        repeat (12) step();
        chk("fair_rem0", rem[0], 0);
        chk("fair_rem1", rem[1], 0);
        chk("fair_full0", full[0], 1'b1);
        chk("fair_full1", full[1], 1'b1);
        chk("fair_nwrites", src_log.size(), 2*NF);
        for (int i = 0; i < src_log.size() && i < 2*NF; i++) begin
            chk($sformatf("fair_order%0d", i), src_log[i], (i + 1) % 2);
        end
        chk("fair_q0_empty", q0.size(), 0);
        chk("fair_q1_empty", q1.size(), 0);

        // ---- squash (rr points at source 1 after the fairness run) ----
        step();
        drive(0, 6'd10, 32'h0000_00A0, 4'b0001, 1'b0, acc);
        drive(1, 6'd13, 32'h1000_00D0, 4'b0100, 1'b1, acc);
        step();
        drive(0, 6'd11, 32'h0000_00B0, 4'b0010, 1'b1, acc);
        idle(1);
        step();
        drive(0, 6'd12, 32'h0000_00C0, 4'b0001, 1'b0, acc);
        step();
        idle(0);
        drive(1, 6'd14, 32'h1000_00E0, 4'b0001, 1'b0, acc);
        bus.branch_hazard       = 1'b1;
        bus.hazard_context_info = 4'b0001;
        @(negedge clk);
        chk("sq_gate_order", w_order, 1'b0);
        chk("sq_gate_pa", w_pa, 6'd10);
        step();
        bus.branch_hazard       = 1'b0;
        bus.hazard_context_info = '0;
        idle(1);
        @(negedge clk);
        chk("sq_b_order", w_order, 1'b1);
        chk("sq_b_pa", w_pa, 6'd11);
        repeat (6) step();
        chk("sq_q0_empty", q0.size(), 0);
        chk("sq_q1_empty", q1.size(), 0);

        // ---- reset mid-stream ----
        for (int cyc = 0; cyc < 12; cyc++) begin
            step();
            drive(0, 6'(33 + cyc), 32'h0000_0C00 + 32'(cyc), 4'b1000, 1'b1, acc);
            drive(1, 6'(49 + cyc), 32'h1000_0C00 + 32'(cyc), 4'b1000, 1'b1, acc);
        end
        step();
        idle(0); idle(1);
        rstn = 1'b1;
        @(negedge clk);
        step();
        rstn = 1'b0;
        q0.delete();
        q1.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("mid_quiet%0d", i), w_order, 1'b0);
            step();
        end
        chk("mid_ready", bus.src_ready, 2'b11);
        drive(0, 6'd21, 32'h0000_0A21, 4'b0001, 1'b1, acc);
        drive(1, 6'd22, 32'h1000_0A22, 4'b0001, 1'b1, acc);
        step();
        idle(0); idle(1);
        @(negedge clk);
        chk("mid_c0_order", w_order, 1'b0);
        step();
        @(negedge clk);
        chk("mid_first_order", w_order, 1'b1);
        chk("mid_first_data", w_d, 32'h0000_0A21);
        step();
        @(negedge clk);
        chk("mid_second_order", w_order, 1'b1);
        chk("mid_second_data", w_d, 32'h1000_0A22);
        repeat (4) step();
        chk("mid_q0_empty", q0.size(), 0);
        chk("mid_q1_empty", q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
